// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman host/player status link.
package hangman_pkg;

    localparam logic [7:0]  STATUS_HEADER = 8'hA5;
    localparam int unsigned STATUS_LEN    = 5;

    typedef struct packed {
        logic [7:0] letter;
        logic [2:0] incorrect;
        logic [2:0] correct;
        logic [4:0] index_correct;
        logic       game_end;
    } status_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ACK   = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

endpackage

// File: rtl/status_pack.sv
// Maps a status snapshot and byte index to the wire byte, including the XOR checksum.
module status_pack
    import hangman_pkg::*;
#(
    parameter logic [7:0] HEADER = STATUS_HEADER
) (
    input  status_t    status,
    input  logic [2:0] idx,
    output logic [7:0] data
);

    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;

    assign b1 = status.letter;
    assign b2 = {status.incorrect, status.index_correct};
    assign b3 = {status.game_end, 4'b0000, status.correct};

    always_comb begin
        data = '0;
        case (idx)
            3'd0:    data = HEADER;
            3'd1:    data = b1;
            3'd2:    data = b2;
            3'd3:    data = b3;
            3'd4:    data = b1 ^ b2 ^ b3;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/status_link_tx.sv
// Host-side status packet framer: snapshots a game result and feeds it byte-wise to uart_tx.
module status_link_tx
    import hangman_pkg::*;
#(
    parameter logic [7:0]  HEADER      = STATUS_HEADER,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       update,
    input  logic [7:0] letter,
    input  logic [2:0] incorrect,
    input  logic [2:0] correct,
    input  logic [4:0] indexCorrect,
    input  logic       gameEnd,
    input  logic       transmit_ready,
    output logic       tx_ctrl,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       overrun,
    output logic       handshake_err
);

    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

    tx_state_t     state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    status_t       snap_q, snap_d;
    status_t       pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_ctrl_q, tx_ctrl_d;
    logic          overrun_q, overrun_d;
    logic          herr_q, herr_d;
    status_t       fields;
    logic [7:0]    pack_byte;

    assign fields = '{letter: letter, incorrect: incorrect, correct: correct,
                      index_correct: indexCorrect, game_end: gameEnd};

    status_pack #(
        .HEADER (HEADER)
    ) u_pack (
        .status (snap_q),
        .idx    (idx_q),
        .data   (pack_byte)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        timer_d      = timer_q;
        tx_ctrl_d    = 1'b0;
        overrun_d    = overrun_q;
        herr_d       = herr_q;

        // Pending capture happens before DRAIN looks at it, so a same-cycle update is promoted.
        if (update && state_q != IDLE) begin
            pend_d       = fields;
            pend_valid_d = 1'b1;
            if (pend_valid_q) overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (update) begin
                    snap_d  = fields;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (transmit_ready) begin
                    tx_ctrl_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                if (!transmit_ready) begin
                    state_d = DRAIN;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    herr_d  = 1'b1;
                    state_d = DRAIN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: begin
                if (transmit_ready) begin
                    if (idx_q < 3'(STATUS_LEN - 1)) begin
                        idx_d   = idx_q + 3'd1;
                        state_d = LOAD;
                    end else if (pend_valid_d) begin
                        snap_d       = pend_d;
                        pend_valid_d = 1'b0;
                        idx_d        = '0;
                        state_d      = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            timer_q      <= '0;
            tx_ctrl_q    <= 1'b0;
            overrun_q    <= 1'b0;
            herr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            timer_q      <= timer_d;
            tx_ctrl_q    <= tx_ctrl_d;
            overrun_q    <= overrun_d;
            herr_q       <= herr_d;
        end
    end

    // Byte is only presented while a handshake is open; zero otherwise.
    assign tx_byte       = (state_q == LOAD || state_q == ACK) ? pack_byte : 8'h00;
    assign tx_ctrl       = tx_ctrl_q;
    assign busy          = (state_q != IDLE) | pend_valid_q;
    assign overrun       = overrun_q;
    assign handshake_err = herr_q;

endmodule
